// File: rtl/clk_gate_ctl_pkg.sv
// Shared types and limits for the block-level clock gate sequencer.
package clk_gate_ctl_pkg;

  typedef enum logic [1:0] {
    CG_ACTIVE   = 2'd0,
    CG_IDLE_CNT = 2'd1,
    CG_GATED    = 2'd2,
    CG_WAKE     = 2'd3
  } cg_state_t;

  localparam int unsigned CG_WAKE_LAT_MAX = 255;

endpackage

// File: rtl/clk_gate_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module clk_gate_sat_cnt #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [Width-1:0] cnt
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/clk_gate_en_ctl.sv
// Clock gate enable sequencer: gates after idle hysteresis, re-enables on wake and
// holds ready low until the gated domain has settled for WAKE_LAT cycles.
module clk_gate_en_ctl
  import clk_gate_ctl_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned WAKE_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               force_on,
  input  logic               gate_allow,
  input  logic [CNT_W-1:0]   idle_hyst,
  output logic               clk_en,
  output logic               ready,
  output logic               gated,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   gate_events
);

  localparam int unsigned WakeW = $clog2(CG_WAKE_LAT_MAX + 1);
  localparam logic [WakeW-1:0] WakeLast = WakeW'(WAKE_LAT - 1);

  cg_state_t        state_d, state_q;
  logic             clk_en_d, clk_en_q;
  logic             ready_d, ready_q;
  logic             gated_d, gated_q;
  logic             busy;
  logic             idle_clr, idle_inc;
  logic             wake_clr, wake_inc;
  logic             ev_inc;
  logic [CNT_W-1:0] idle_cnt;
  logic [WakeW-1:0] wake_cnt;

  assign busy = (|req) | force_on | ~gate_allow;

  always_comb begin
    state_d  = state_q;
    clk_en_d = clk_en_q;
    ready_d  = ready_q;
    gated_d  = gated_q;
    idle_clr = 1'b1;
    idle_inc = 1'b0;
    wake_clr = 1'b1;
    wake_inc = 1'b0;
    ev_inc   = 1'b0;
    unique case (state_q)
      CG_ACTIVE: begin
        if (!busy && (idle_hyst != '0)) begin
          state_d  = CG_IDLE_CNT;
          idle_clr = 1'b0;
          idle_inc = 1'b1;
        end
      end
      CG_IDLE_CNT: begin
        // busy is checked first so a late request always beats the gating decision
        if (busy || (idle_hyst == '0)) begin
          state_d = CG_ACTIVE;
        end else if (idle_cnt >= idle_hyst) begin
          state_d  = CG_GATED;
          clk_en_d = 1'b0;
          ready_d  = 1'b0;
          gated_d  = 1'b1;
          ev_inc   = 1'b1;
        end else begin
          idle_clr = 1'b0;
          idle_inc = 1'b1;
        end
      end
      CG_GATED: begin
        if (busy) begin
          state_d  = CG_WAKE;
          clk_en_d = 1'b1;
          gated_d  = 1'b0;
        end
      end
      CG_WAKE: begin
        if (wake_cnt == WakeLast) begin
          state_d = CG_ACTIVE;
          ready_d = 1'b1;
        end else begin
          wake_clr = 1'b0;
          wake_inc = 1'b1;
        end
      end
      default: begin
        state_d  = CG_ACTIVE;
        clk_en_d = 1'b1;
        ready_d  = 1'b1;
        gated_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CG_ACTIVE;
      clk_en_q <= 1'b1;
      ready_q  <= 1'b1;
      gated_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      clk_en_q <= clk_en_d;
      ready_q  <= ready_d;
      gated_q  <= gated_d;
    end
  end

  clk_gate_sat_cnt #(
    .Width (CNT_W)
  ) u_idle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (idle_clr),
    .inc (idle_inc),
    .cnt (idle_cnt)
  );

  clk_gate_sat_cnt #(
    .Width (WakeW)
  ) u_wake_cnt (
    .clk (clk),
    .rst (rst),
    .clr (wake_clr),
    .inc (wake_inc),
    .cnt (wake_cnt)
  );

  clk_gate_sat_cnt #(
    .Width (CNT_W)
  ) u_gate_events (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (ev_inc),
    .cnt (gate_events)
  );

  assign clk_en = clk_en_q;
  assign ready  = ready_q;
  assign gated  = gated_q;
  assign state  = state_q;

endmodule

// File: tb/tb_clk_gate_en_ctl.sv
// Directed bench for clk_gate_en_ctl; a second CNT_W=3 instance covers event saturation.
module tb_clk_gate_en_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       force_on;
  logic       gate_allow;
  logic [7:0] idle_hyst;
  logic       clk_en, ready, gated;
  logic [1:0] state;
  logic [7:0] gate_events;

  logic [2:0] idle_hyst2;
  logic       clk_en2, ready2, gated2;
  logic [1:0] state2;
  logic [2:0] gate_events2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  clk_gate_en_ctl #(
    .NUM_REQ  (4),
    .CNT_W    (8),
    .WAKE_LAT (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .force_on    (force_on),
    .gate_allow  (gate_allow),
    .idle_hyst   (idle_hyst),
    .clk_en      (clk_en),
    .ready       (ready),
    .gated       (gated),
    .state       (state),
    .gate_events (gate_events)
  );

  clk_gate_en_ctl #(
    .NUM_REQ  (4),
    .CNT_W    (3),
    .WAKE_LAT (2)
  ) dut_sat (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .force_on    (force_on),
    .gate_allow  (gate_allow),
    .idle_hyst   (idle_hyst2),
    .clk_en      (clk_en2),
    .ready       (ready2),
    .gated       (gated2),
    .state       (state2),
    .gate_events (gate_events2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gated();
    int n = 0;
    while (!gated && n < 20) begin
      step();
      n++;
    end
    check("wait_gated", {31'd0, gated}, 32'd1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 20) begin
      step();
      n++;
    end
    check("wait_ready", {31'd0, ready}, 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    req        = 4'd0;
    force_on   = 1'b0;
    gate_allow = 1'b1;
    idle_hyst  = 8'd4;
    idle_hyst2 = 3'd4;
    step();
    step();
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_clk_en", {31'd0, clk_en}, 32'd1);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_gated", {31'd0, gated}, 32'd0);
    check("rst_events", {24'd0, gate_events}, 32'd0);

    // Idle from reset: gates after five edges with hysteresis 4.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("idle_clk_en_on", {31'd0, clk_en}, 32'd1);
      check("idle_ready_on", {31'd0, ready}, 32'd1);
    end
    step();
    check("gate_clk_en", {31'd0, clk_en}, 32'd0);
    check("gate_gated", {31'd0, gated}, 32'd1);
    check("gate_ready", {31'd0, ready}, 32'd0);
    check("gate_state", {30'd0, state}, 32'd2);
    check("gate_events1", {24'd0, gate_events}, 32'd1);

    // Wake on req[2]; ready two cycles after clk_en.
    req = 4'b0100;
    step();
    req = 4'd0;
    check("wake_clk_en", {31'd0, clk_en}, 32'd1);
    check("wake_ready0", {31'd0, ready}, 32'd0);
    check("wake_state", {30'd0, state}, 32'd3);
    step();
    check("wake_ready1", {31'd0, ready}, 32'd0);
    step();
    check("wake_ready2", {31'd0, ready}, 32'd1);
    check("wake_active", {30'd0, state}, 32'd0);
    check("wake_events", {24'd0, gate_events}, 32'd1);

    // Interrupted idle window, then a full fresh window.
    step();
    check("intr_idle_state", {30'd0, state}, 32'd1);
    step();
    req = 4'b0001;
    step();
    req = 4'd0;
    check("intr_state", {30'd0, state}, 32'd0);
    check("intr_events", {24'd0, gate_events}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("fresh_clk_en_on", {31'd0, clk_en}, 32'd1);
    end
    step();
    check("fresh_gated", {31'd0, gated}, 32'd1);
    check("fresh_events", {24'd0, gate_events}, 32'd2);

    // gate_allow dropping while gated wakes; input changes during WAKE are ignored.
    gate_allow = 1'b0;
    step();
    gate_allow = 1'b1;
    check("deny_state", {30'd0, state}, 32'd3);
    check("deny_clk_en", {31'd0, clk_en}, 32'd1);
    step();
    check("deny_ready1", {31'd0, ready}, 32'd0);
    check("deny_in_wake", {30'd0, state}, 32'd3);
    step();
    check("deny_ready2", {31'd0, ready}, 32'd1);

    // force_on holds the clock on.
    force_on = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("force_state", {30'd0, state}, 32'd0);
    end
    force_on  = 1'b0;
    idle_hyst = 8'd0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("hyst0_state", {30'd0, state}, 32'd0);
    end

    // Lowering idle_hyst mid-count gates on the next cycle.
    idle_hyst = 8'd8;
    step();
    step();
    step();
    check("live_counting", {30'd0, state}, 32'd1);
    idle_hyst = 8'd2;
    step();
    check("live_gated", {31'd0, gated}, 32'd1);
    check("live_events", {24'd0, gate_events}, 32'd3);

    // Reset in WAKE with wake_cnt=0.
    req = 4'b1000;
    step();
    req = 4'd0;
    check("pre_rst_wake", {30'd0, state}, 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_state", {30'd0, state}, 32'd0);
    check("midrst_clk_en", {31'd0, clk_en}, 32'd1);
    check("midrst_ready", {31'd0, ready}, 32'd1);
    check("midrst_events", {24'd0, gate_events}, 32'd0);

    // Ten gate/wake rounds: 8-bit count reaches 10, 3-bit count sticks at 7.
    idle_hyst  = 8'd2;
    idle_hyst2 = 3'd2;
    for (int i = 0; i < 10; i++) begin
      wait_gated();
      check("sat_lockstep_gated", {31'd0, gated2}, 32'd1);
      req = 4'b0010;
      step();
      req = 4'd0;
      wait_ready();
    end
    check("sat_events_wide", {24'd0, gate_events}, 32'd10);
    check("sat_events_narrow", {29'd0, gate_events2}, 32'd7);
    check("sat_narrow_state", {30'd0, state2}, {30'd0, state});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_gate_en_ctl.md
Name: clk_gate_en_ctl

Overview:
- Sequencer for a block-level clock gate cell.
- Watches NUM_REQ requester activity lines and idles the clock after a programmable hysteresis of consecutive idle cycles.
- Drives the gate cell's enable input.
- On any wake request, re-enables the clock and holds off `ready` until the gated domain has settled for WAKE_LAT cycles.
- Sits in the always-on clock domain, beside the gate cell it controls.

Parameters:
- NUM_REQ, 4, number of requester activity inputs.
- CNT_W, 8, width of the idle hysteresis counter and the gate-event counter.
- WAKE_LAT, 2, cycles after clk_en rises before ready asserts; legal range 1..255.

Ports:
- clk  input  1  free-running (ungated) clock.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester activity/wake; level, any bit set = busy.
- force_on  input  1  override; keeps or brings the clock on.
- gate_allow  input  1  power-manager permission to gate; 0 blocks gating and wakes if gated.
- idle_hyst  input  CNT_W  idle cycles required before gating; 0 = gating disabled.
- clk_en  output  1  registered enable to the clock gate cell.
- ready  output  1  gated domain clock stable and usable.
- gated  output  1  status: clock currently gated.
- state  output  2  FSM state encoding, for debug.
- gate_events  output  CNT_W  saturating count of GATED entries.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=ACTIVE, clk_en=1, ready=1, gated=0.
  - idle_cnt=0, wake_cnt=0, gate_events=0.
  - The clock always runs out of reset.
- All outputs are registered; there is no combinational path from inputs to outputs.
- busy = |req | force_on | !gate_allow.
- FSM states: ACTIVE=0, IDLE_CNT=1, GATED=2, WAKE=3.
- ACTIVE (clk_en=1, ready=1, gated=0):
  - if !busy and idle_hyst!=0: go to IDLE_CNT, idle_cnt=1.
  - otherwise stay in ACTIVE.
- IDLE_CNT (clk_en=1, ready=1):
  - if busy: go to ACTIVE, idle_cnt=0.
  - else if idle_hyst==0: go to ACTIVE.
  - else if idle_cnt >= idle_hyst: go to GATED, clk_en<=0, ready<=0, gated<=1, gate_events++ (saturates at all-ones).
  - else idle_cnt++.
  - idle_hyst is compared live; lowering it mid-count can trigger gating on the next cycle.
  - idle_cnt saturates; it never wraps.
- GATED (clk_en=0, ready=0, gated=1):
  - if busy: go to WAKE, clk_en<=1, gated<=0, wake_cnt=0.
  - otherwise stay in GATED.
- WAKE (clk_en=1, ready=0):
  - wake_cnt++ each cycle.
  - when wake_cnt==WAKE_LAT-1: go to ACTIVE, ready<=1.
  - Input changes are ignored in WAKE; the state cannot return to GATED before reaching ACTIVE.
- Timing, idle to gated:
  - first idle cycle t in ACTIVE → IDLE_CNT at t+1.
  - clk_en=0 at t+1+idle_hyst, provided idle persists.
- Timing, gated to ready:
  - busy sampled at cycle t in GATED → clk_en=1 at t+1.
  - ready=1 at t+1+WAKE_LAT.
- Simultaneous events:
  - busy rising on the same cycle the count reaches idle_hyst: busy wins, go to ACTIVE, no gating, no event count.
- rst mid-WAKE or mid-GATED: immediate return to reset values; clk_en=1 next cycle.
- Requesters must not issue work while ready=0; the block does not queue or acknowledge requests.

Decomposition:
- Package clk_gate_ctl_pkg:
  - typedef enum logic[1:0] cg_state_t {CG_ACTIVE, CG_IDLE_CNT, CG_GATED, CG_WAKE}.
  - constant CG_WAKE_LAT_MAX=255.
- One natural sub-module: clk_gate_sat_cnt, a parameterised saturating up-counter with sync clear.
  - Instantiated for idle_cnt, wake_cnt and gate_events.
- The gate cell itself is instantiated by the parent, not inside this block.

Test Plan:
1. Reset then idle, req=0, gate_allow=1, idle_hyst=4, deassert rst at cycle 0 → clk_en=1, ready=1 through cycle 4; clk_en=0, gated=1, gate_events=1 at cycle 5.
2. From GATED, pulse req[2]=1 at cycle t, WAKE_LAT=2 → clk_en=1 at t+1, ready=0 at t+1 and t+2, ready=1 at t+3, state=ACTIVE.
3. Idle count interrupted, idle_hyst=4, req[0] asserted on the 3rd idle cycle → state returns to ACTIVE, no gating, gate_events unchanged; a fresh 4-cycle idle window is required.
4. Overrides:
   - force_on=1 held with req=0 → never gates.
   - gate_allow 1→0 while GATED → wake sequence, ready=1 after WAKE_LAT.
   - idle_hyst=0 → never leaves ACTIVE.
5. Saturation, CNT_W=3 build, 10 gate/wake cycles → gate_events sticks at 7.
6. rst asserted mid-WAKE (wake_cnt=0) → next cycle state=ACTIVE, clk_en=1, ready=1, gate_events=0.
